embedded_sync_encoder: RTL and testbench

Generates a continuous camera-style word stream with embedded sync codes (0 = frame start, 1 = line start, 2 = line end, 3 = frame end) from a parallel pixel source. It is the transmit-side counterpart of the deserializer unit's sync detector and sits ahead of the serializer in the camera-emulation and loopback path. Frame geometry and blanking are fixed by parameters. Pixel words are guaranteed never to collide with the sync codes.

---
 rtl/embedded_sync_encoder.sv | 185 ++++++++++++++++++
 tb/tb_embedded_sync_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/embedded_sync_encoder.sv
// Camera-style word stream generator with embedded sync codes (FS=0, LS=1, LE=2, FE=3).
// Define EMBEDDED_SYNC_TEST_PATTERN_EN to replace the pixel handshake with a moving ramp pattern.
module embedded_sync_encoder #(
  parameter int VIDEO_BIT_WIDTH  = 8,
  parameter int OUTPUT_BIT_WIDTH = 10,
  parameter int H_ACTIVE         = 752,
  parameter int V_ACTIVE         = 480,
  parameter int H_BLANK          = 94,
  parameter int V_BLANK          = 45,
  parameter int BLANK_WORD       = 4
) (
  input  logic                        pxclk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        word_en,
  input  logic                        pix_valid,
  input  logic [VIDEO_BIT_WIDTH-1:0]  pix_data,
  output logic                        pix_ready,
  output logic                        tx_data_valid,
  output logic [OUTPUT_BIT_WIDTH-1:0] tx_data_payload,
  output logic                        frame_active,
  output logic                        underflow,
  input  logic                        underflow_clr
);

  localparam int VW   = VIDEO_BIT_WIDTH;
  localparam int OW   = OUTPUT_BIT_WIDTH;
  localparam int PAD  = OW - VW;
  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int CW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int LW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE - 1);
  localparam logic [LW-1:0] V_LAST  = LW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] HB_LAST = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [BW-1:0] VB_LAST = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  localparam logic [OW-1:0] CODE_FS   = OW'(0);
  localparam logic [OW-1:0] CODE_LS   = OW'(1);
  localparam logic [OW-1:0] CODE_LE   = OW'(2);
  localparam logic [OW-1:0] CODE_FE   = OW'(3);
  localparam logic [OW-1:0] MIN_WORD  = OW'(4);
  localparam logic [OW-1:0] BLANK_VAL = OW'(BLANK_WORD);

  typedef enum logic [2:0] {
    IDLE, FS, LS, ACTIVE, LE, HBLANK, FE, VBLANK
  } state_t;

  state_t        state;
  logic [CW-1:0] col_cnt;
  logic [LW-1:0] line_cnt;
  logic [BW-1:0] blank_cnt;

  logic [VW-1:0] pix_value;
  logic          pix_present;
  logic [OW-1:0] pix_shifted;
  logic [OW-1:0] active_word;
  logic          underflow_set;

`ifdef EMBEDDED_SYNC_TEST_PATTERN_EN
  logic [VW-1:0] frame_cnt;
  logic          unused_pix;

  // Ramp shifts by one code per frame so consecutive frames are distinguishable.
  assign pix_value     = VW'(col_cnt) + frame_cnt;
  assign pix_present   = 1'b1;
  assign pix_ready     = 1'b0;
  assign underflow_set = 1'b0;
  assign unused_pix    = ^{pix_valid, pix_data};
`else
  assign pix_value     = pix_data;
  assign pix_present   = pix_valid;
  assign pix_ready     = (state == ACTIVE) && word_en;
  assign underflow_set = (state == ACTIVE) && word_en && !pix_valid;
`endif

  assign pix_shifted = {pix_value, {PAD{1'b0}}};

  // Pixel codes must never alias a sync code; a missing pixel becomes the lowest legal word.
  always_comb begin
    // NOTE: default first so every path assigns active_word and no latch is inferred.
    active_word = MIN_WORD;
    if (pix_present && (pix_shifted >= MIN_WORD))
      active_word = pix_shifted;
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pxclk) begin
    if (reset) begin
      state           <= IDLE;
      col_cnt         <= '0;
      line_cnt        <= '0;
      blank_cnt       <= '0;
      tx_data_valid   <= 1'b0;
      tx_data_payload <= BLANK_VAL;
      frame_active    <= 1'b0;
      underflow       <= 1'b0;
`ifdef EMBEDDED_SYNC_TEST_PATTERN_EN
      frame_cnt       <= '0;
`endif
    end else begin
      tx_data_valid <= word_en;

      // A new underflow event wins over a simultaneous clear.
      if (underflow_set)
        underflow <= 1'b1;
      else if (underflow_clr)
        underflow <= 1'b0;

      if (word_en) begin
        case (state)
          IDLE: begin
            tx_data_payload <= BLANK_VAL;
            frame_active    <= 1'b0;
            if (enable)
              state <= FS;
          end
          FS: begin
            tx_data_payload <= CODE_FS;
            frame_active    <= 1'b1;
            line_cnt        <= '0;
            state           <= LS;
          end
          LS: begin
            tx_data_payload <= CODE_LS;
            col_cnt         <= '0;
            state           <= ACTIVE;
          end
          ACTIVE: begin
            tx_data_payload <= active_word;
            if (col_cnt == H_LAST)
              state <= LE;
            else
              col_cnt <= col_cnt + CW'(1);
          end
          LE: begin
            tx_data_payload <= CODE_LE;
            if (line_cnt == V_LAST) begin
              state <= FE;
            end else if (H_BLANK == 0) begin
              line_cnt <= line_cnt + LW'(1);
              state    <= LS;
            end else begin
              blank_cnt <= '0;
              state     <= HBLANK;
            end
          end
          HBLANK: begin
            tx_data_payload <= BLANK_VAL;
            if (blank_cnt == HB_LAST) begin
              line_cnt <= line_cnt + LW'(1);
              state    <= LS;
            end else begin
              blank_cnt <= blank_cnt + BW'(1);
            end
          end
          FE: begin
            tx_data_payload <= CODE_FE;
            line_cnt        <= '0;
`ifdef EMBEDDED_SYNC_TEST_PATTERN_EN
            frame_cnt       <= frame_cnt + VW'(1);
`endif
            if (V_BLANK == 0) begin
              state <= enable ? FS : IDLE;
            end else begin
              blank_cnt <= '0;
              state     <= VBLANK;
            end
          end
          VBLANK: begin
            tx_data_payload <= BLANK_VAL;
            frame_active    <= 1'b0;
            if (blank_cnt == VB_LAST)
              state <= enable ? FS : IDLE;
            else
              blank_cnt <= blank_cnt + BW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_embedded_sync_encoder.sv
// Scoreboard bench for embedded_sync_encoder on a 4x2 geometry with short blanking.
// A table of word kinds per frame slot produces the expected stream independently of the FSM.
module tb_embedded_sync_encoder;

  localparam int VW   = 8;
  localparam int OW   = 10;
  localparam int HA   = 4;
  localparam int VA   = 2;
  localparam int HB   = 2;
  localparam int VB   = 3;
  localparam int BLK  = 4;
  localparam int FLEN = 19;

  logic          pxclk = 1'b0;
  logic          reset;
  logic          enable;
  logic          word_en;
  logic          pix_valid;
  logic [VW-1:0] pix_data;
  logic          pix_ready;
  logic          tx_data_valid;
  logic [OW-1:0] tx_data_payload;
  logic          frame_active;
  logic          underflow;
  logic          underflow_clr;

  embedded_sync_encoder #(
    .VIDEO_BIT_WIDTH (VW),
    .OUTPUT_BIT_WIDTH(OW),
    .H_ACTIVE        (HA),
    .V_ACTIVE        (VA),
    .H_BLANK         (HB),
    .V_BLANK         (VB),
    .BLANK_WORD      (BLK)
  ) dut (
    .pxclk          (pxclk),
    .reset          (reset),
    .enable         (enable),
    .word_en        (word_en),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .tx_data_valid  (tx_data_valid),
    .tx_data_payload(tx_data_payload),
    .frame_active   (frame_active),
    .underflow      (underflow),
    .underflow_clr  (underflow_clr)
  );

  always #5 pxclk = ~pxclk;

  typedef enum {K_FS, K_LS, K_PX, K_LE, K_BL, K_FE} kind_t;
  kind_t kinds [FLEN] = '{K_FS, K_LS, K_PX, K_PX, K_PX, K_PX, K_LE, K_BL, K_BL,
                          K_LS, K_PX, K_PX, K_PX, K_PX, K_LE, K_FE, K_BL, K_BL, K_BL};

  typedef struct packed {
    logic [OW-1:0] payload;
    logic          active;
  } exp_t;

  exp_t sb [$];

  int vectors     = 0;
  int miscompares = 0;

  bit in_frame   = 0;
  bit start_next = 0;
  bit m_uf       = 0;
  int pos        = 0;
  int slot       = 0;
  int frame_no   = 0;
  int pd_ctr     = 10;
  int pix_mode   = 0;
  int uf_slot    = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] to_word(input logic [VW-1:0] v);
    logic [OW-1:0] w;
    w = OW'(v) << (OW - VW);
    return (w < 4) ? OW'(4) : w;
  endfunction

  task automatic step(input bit we, input bit en, input bit clr, input bit rst);
    bit            is_px;
    bit            pv;
    logic [VW-1:0] pd;
    exp_t          e;
    exp_t          got;
    int            col;
    @(negedge pxclk);
    is_px = in_frame && (kinds[pos] == K_PX);
    pv    = !(is_px && slot == uf_slot);
    pd    = (pix_mode != 0) ? ((slot % 2 != 0) ? 8'd255 : 8'd0) : VW'(pd_ctr);
    reset         = rst;
    enable        = en;
    word_en       = we;
    pix_valid     = pv;
    pix_data      = pd;
    underflow_clr = clr;
    #1;
    if (!rst) begin
`ifdef EMBEDDED_SYNC_TEST_PATTERN_EN
      check("pix_ready", pix_ready, 1'b0);
`else
      check("pix_ready", pix_ready, is_px && we);
`endif
    end

    if (rst) begin
      in_frame = 0; start_next = 0; m_uf = 0; pos = 0; slot = 0; frame_no = 0;
      sb.delete();
    end else begin
      if (we) begin
        if (in_frame) begin
          e.active = (pos <= 15);
          case (kinds[pos])
            K_FS: e.payload = 0;
            K_LS: e.payload = 1;
            K_LE: e.payload = 2;
            K_FE: e.payload = 3;
            K_BL: e.payload = BLK;
            default: begin
              col = (pos < 10) ? pos - 2 : pos - 10;
`ifdef EMBEDDED_SYNC_TEST_PATTERN_EN
              e.payload = to_word(VW'(col + frame_no));
`else
              e.payload = pv ? to_word(pd) : OW'(4);
              if (pv && pix_mode == 0) pd_ctr++;
`endif
            end
          endcase
          if (kinds[pos] == K_FE) frame_no++;
          if (kinds[pos] == K_PX) slot++;
          pos++;
          if (pos == FLEN) begin
            in_frame   = 0;
            start_next = en;
          end
        end else if (start_next) begin
          e.payload = 0; e.active = 1;
          in_frame = 1; pos = 1; slot = 0;
        end else begin
          e.payload = BLK; e.active = 0;
          start_next = en;
        end
        sb.push_back(e);
      end
`ifndef EMBEDDED_SYNC_TEST_PATTERN_EN
      if (we && is_px && !pv) m_uf = 1;
      else if (clr) m_uf = 0;
`endif
    end

    @(posedge pxclk);
    #1;
    check("tx_data_valid", tx_data_valid, we && !rst);
    if (rst) begin
      check("rst_payload", tx_data_payload, BLK);
      check("rst_frame_active", frame_active, 1'b0);
    end else if (tx_data_valid) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        got = sb.pop_front();
        check("payload", tx_data_payload, got.payload);
        check("frame_active", frame_active, got.active);
      end
    end
    check("underflow", underflow, m_uf);
  endtask

  initial begin
    reset = 1; enable = 0; word_en = 0; pix_valid = 0; pix_data = '0; underflow_clr = 0;

    // Reset state, then two full frames of the basic geometry.
    repeat (2) step(1, 1, 0, 1);
    repeat (40) step(1, 1, 0, 0);

    // Boundary pixel values 0 and 255.
    step(1, 1, 0, 1);
    pix_mode = 1;
    repeat (21) step(1, 1, 0, 0);

    // Missing pixel in the third slot, then clear the sticky flag.
    step(1, 1, 0, 1);
    pix_mode = 0; pd_ctr = 10; uf_slot = 2;
    repeat (21) step(1, 1, 0, 0);
    uf_slot = -1;
    step(1, 1, 1, 0);
    repeat (3) step(1, 1, 0, 0);

    // Strobe toggling: stream must be the same, one word per strobe.
    step(1, 1, 0, 1);
    pd_ctr = 10;
    for (int i = 0; i < 80; i++) step(i % 2 == 0, 1, 0, 0);

    // Enable dropped during line 0: frame closes, then idle blanking only.
    step(1, 1, 0, 1);
    repeat (5) step(1, 1, 0, 0);
    repeat (30) step(1, 0, 0, 0);

    // Reset in the middle of a line.
    repeat (6) step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    repeat (4) step(1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
